// File: rtl/idma_nd_backend_stub.sv
// N-D request responder: expands each request into 1-D bursts and returns one burst response
// per burst after a fixed latency, through a bounded response FIFO.
package idma_nd_backend_stub_pkg;
    localparam int unsigned NumDim    = 3;
    localparam int unsigned RepsWidth = 32;
    localparam int unsigned AddrWidth = 32;

    typedef struct packed {
        logic [AddrWidth-1:0] length;
        logic [AddrWidth-1:0] src_addr;
        logic [AddrWidth-1:0] dst_addr;
    } burst_req_t;

    typedef struct packed {
        logic [RepsWidth-1:0] reps;
        logic [AddrWidth-1:0] src_strides;
        logic [AddrWidth-1:0] dst_strides;
    } d_req_t;

    typedef struct packed {
        d_req_t [NumDim-2:0] d_req;
        burst_req_t          burst_req;
    } nd_req_t;

    typedef struct packed {
        logic [1:0]           cause;
        logic [1:0]           err_type;
        logic [AddrWidth-1:0] burst_addr;
        logic                 error;
        logic                 last;
    } rsp_t;
endpackage

module idma_nd_backend_stub #(
    parameter int unsigned NumDim       = 3,
    parameter int unsigned Latency      = 4,
    parameter int unsigned RspFifoDepth = 4,
    parameter int unsigned RepsWidth    = 32,
    parameter type idma_nd_req_t        = idma_nd_backend_stub_pkg::nd_req_t,
    parameter type idma_rsp_t           = idma_nd_backend_stub_pkg::rsp_t
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  idma_nd_req_t nd_req_i,
    input  logic         nd_req_valid_i,
    output logic         nd_req_ready_o,
    output idma_rsp_t    burst_rsp_o,
    output logic         burst_rsp_valid_o,
    input  logic         burst_rsp_ready_i,
    output logic         busy_o,
    output logic [31:0]  rsp_count_o
);

    localparam int unsigned CntW = $clog2(RspFifoDepth + 1);
    localparam int unsigned PtrW = (RspFifoDepth > 1) ? $clog2(RspFifoDepth) : 1;
    localparam logic [CntW-1:0] DepthC = CntW'(RspFifoDepth);

    typedef enum logic [0:0] {StIdle, StExpand} state_e;

    state_e               state;
    logic [RepsWidth-1:0] r1, r2, i1, i2;
    logic [RepsWidth-1:0] req_r1, req_r2;
    logic                 len_zero, req_len_zero;
    logic                 issue, last_burst, i1_wrap, credit, push, pop, rsp_valid;
    logic [2:0]           issue_ent, pipe_out;
    logic [CntW-1:0]      fifo_cnt, inflight;
    logic [PtrW-1:0]      wr_ptr, rd_ptr;
    logic                 fifo_last [RspFifoDepth];
    logic                 fifo_err  [RspFifoDepth];
    logic [31:0]          rsp_count;
    logic                 unused_req;

    assign req_r1       = nd_req_i.d_req[0].reps;
    assign req_r2       = (NumDim > 2) ? nd_req_i.d_req[1].reps : RepsWidth'(1);
    assign req_len_zero = (nd_req_i.burst_req.length == '0);
    assign unused_req   = ^nd_req_i;

    assign i1_wrap    = (i1 == r1 - RepsWidth'(1));
    assign last_burst = i1_wrap && (i2 == r2 - RepsWidth'(1));

    // A pop this cycle already frees its slot, so the credit check subtracts it.
    assign pop    = rsp_valid && burst_rsp_ready_i;
    assign credit = (inflight - CntW'(pop)) < DepthC;
    assign issue  = (state == StExpand) && credit;

    assign issue_ent = issue ? {1'b1, last_burst, len_zero} : 3'b000;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= StIdle;
            r1       <= '0;
            r2       <= '0;
            i1       <= '0;
            i2       <= '0;
            len_zero <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (nd_req_valid_i) begin
                        r1       <= (req_r1 == '0) ? RepsWidth'(1) : req_r1;
                        r2       <= (req_r2 == '0) ? RepsWidth'(1) : req_r2;
                        len_zero <= req_len_zero;
                        i1       <= '0;
                        i2       <= '0;
                        state    <= StExpand;
                    end
                end
                StExpand: begin
                    if (issue) begin
                        if (last_burst) begin
                            state <= StIdle;
                        end else if (i1_wrap) begin
                            i1 <= '0;
                            i2 <= i2 + RepsWidth'(1);
                        end else begin
                            i1 <= i1 + RepsWidth'(1);
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    // The FIFO write is the final latency stage, so the pipe holds Latency-1 registers.
    if (Latency > 1) begin : g_pipe
        logic [2:0] pipe_q [Latency-1];

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                for (int unsigned k = 0; k < Latency - 1; k++) begin
                    pipe_q[k] <= 3'b000;
                end
            end else begin
                pipe_q[0] <= issue_ent;
                for (int unsigned k = 1; k < Latency - 1; k++) begin
                    pipe_q[k] <= pipe_q[k-1];
                end
            end
        end

        assign pipe_out = pipe_q[Latency-2];
    end else begin : g_no_pipe
        assign pipe_out = issue_ent;
    end

    assign push = pipe_out[2];

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(RspFifoDepth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            fifo_cnt  <= '0;
            inflight  <= '0;
            rsp_count <= '0;
        end else begin
            if (push) begin
                fifo_last[wr_ptr] <= pipe_out[1];
                fifo_err[wr_ptr]  <= pipe_out[0];
                wr_ptr            <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr    <= ptr_inc(rd_ptr);
                rsp_count <= rsp_count + 32'd1;
            end
            fifo_cnt <= fifo_cnt + CntW'(push) - CntW'(pop);
            inflight <= inflight + CntW'(issue) - CntW'(pop);
        end
    end

    assign rsp_valid = (fifo_cnt != '0);

    always_comb begin
        burst_rsp_o = '0;
        if (rsp_valid) begin
            burst_rsp_o.last  = fifo_last[rd_ptr];
            burst_rsp_o.error = fifo_err[rd_ptr];
        end
    end

    assign burst_rsp_valid_o = rsp_valid;
    assign nd_req_ready_o    = (state == StIdle) && !rst_i;
    assign busy_o            = (state == StExpand) || (inflight != '0);
    assign rsp_count_o       = rsp_count;

endmodule

// File: tb/tb_idma_nd_backend_stub.sv
// Bench for idma_nd_backend_stub: directed timing scenarios plus randomized traffic checked
// against a queue-based model of expected responses.
module tb_idma_nd_backend_stub;
    import idma_nd_backend_stub_pkg::*;

    typedef struct packed {
        logic last;
        logic err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    nd_req_t     req;
    logic        req_valid;
    logic        req_ready;
    rsp_t        rsp;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        busy;
    logic [31:0] rsp_count;

    int          n_checks = 0;
    int          n_errors = 0;
    exp_t        exp_q[$];
    exp_t        exp_e;
    int unsigned model_pops = 0;
    logic        prev_stall = 1'b0;
    rsp_t        prev_rsp;
    logic        accepted;

    always #5 clk = ~clk;

    idma_nd_backend_stub #(
        .NumDim      (3),
        .Latency     (4),
        .RspFifoDepth(4),
        .RepsWidth   (32)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .nd_req_i         (req),
        .nd_req_valid_i   (req_valid),
        .nd_req_ready_o   (req_ready),
        .burst_rsp_o      (rsp),
        .burst_rsp_valid_o(rsp_valid),
        .burst_rsp_ready_i(rsp_ready),
        .busy_o           (busy),
        .rsp_count_o      (rsp_count)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int unsigned r1, input int unsigned r2, input int unsigned len);
        req                    = '0;
        req.d_req[0].reps      = r1;
        req.d_req[1].reps      = r2;
        req.burst_req.length   = len;
        req.burst_req.src_addr = $urandom();
        req.burst_req.dst_addr = $urandom();
        req_valid              = 1'b1;
    endtask

    // Reference: an accepted request yields max(r1,1)*max(r2,1) responses, last on the final.
    task automatic model_accept();
        int unsigned n1, n2, total;
        n1    = (req.d_req[0].reps == 0) ? 1 : req.d_req[0].reps;
        n2    = (req.d_req[1].reps == 0) ? 1 : req.d_req[1].reps;
        total = n1 * n2;
        for (int unsigned b = 0; b < total; b++) begin
            exp_e.last = (b == total - 1);
            exp_e.err  = (req.burst_req.length == 0);
            exp_q.push_back(exp_e);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            model_pops = 0;
            prev_stall = 1'b0;
        end else begin
            check("busy", busy, exp_q.size() != 0);
            if (prev_stall) begin
                check("stall_valid", rsp_valid, 1);
                check("stall_data", rsp, prev_rsp);
            end
            if (exp_q.size() == 0) check("spurious_valid", rsp_valid, 0);
            if (rsp_valid && rsp_ready) begin
                check("rsp_count", rsp_count, model_pops);
                if (exp_q.size() != 0) begin
                    exp_e = exp_q.pop_front();
                    check("rsp_last", rsp.last, exp_e.last);
                    check("rsp_error", rsp.error, exp_e.err);
                    check("rsp_other", {rsp.cause, rsp.err_type, rsp.burst_addr}, 0);
                end
                model_pops++;
            end
            prev_stall = rsp_valid && !rsp_ready;
            prev_rsp   = rsp;
            if (req_valid && req_ready) model_accept();
        end
    end

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        tick();
        @(negedge clk);
        check("rst_ready", req_ready, 0);
        check("rst_valid", rsp_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_count", rsp_count, 0);
        check("rst_rsp", rsp, 0);
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        req       = '0;
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        accepted  = 1'b0;

        // Basic expansion: 2x3 bursts accepted in cycle 0.
        do_reset();
        set_req(2, 3, 8);
        @(negedge clk);
        check("basic_accept", req_ready, 1);
        for (int c = 1; c <= 12; c++) begin
            tick();
            req_valid = 1'b0;
            @(negedge clk);
            check("basic_valid", rsp_valid, (c >= 5 && c <= 10));
            check("basic_last", rsp_valid && rsp.last, c == 10);
            check("basic_ready", req_ready, c >= 7);
        end
        check("basic_count", rsp_count, 6);

        // Zero reps collapse to a single burst.
        do_reset();
        set_req(0, 0, 4);
        @(negedge clk);
        check("zr_accept", req_ready, 1);
        for (int c = 1; c <= 8; c++) begin
            tick();
            req_valid = 1'b0;
            @(negedge clk);
            check("zr_valid", rsp_valid, c == 5);
            check("zr_last", rsp_valid && rsp.last, c == 5);
        end
        check("zr_count", rsp_count, 1);

        // Backpressure: four credits fill, issue stalls, then drains in order.
        do_reset();
        rsp_ready = 1'b0;
        set_req(8, 1, 16);
        @(negedge clk);
        check("bp_accept", req_ready, 1);
        for (int c = 1; c <= 29; c++) begin
            tick();
            req_valid = 1'b0;
            rsp_ready = (c >= 20);
            @(negedge clk);
            check("bp_valid", rsp_valid, (c >= 5 && c <= 27));
            check("bp_last", rsp_valid && rsp.last, c == 27);
            check("bp_ready", req_ready, c >= 24);
        end
        check("bp_count", rsp_count, 8);

        // Zero length marks every response as an error.
        do_reset();
        set_req(3, 1, 0);
        @(negedge clk);
        check("zl_accept", req_ready, 1);
        for (int c = 1; c <= 10; c++) begin
            tick();
            req_valid = 1'b0;
            @(negedge clk);
            check("zl_valid", rsp_valid, (c >= 5 && c <= 7));
            check("zl_error", rsp_valid && rsp.error, (c >= 5 && c <= 7));
            check("zl_last", rsp_valid && rsp.last, c == 7);
        end
        check("zl_count", rsp_count, 3);

        // Back-to-back: B held valid, accepted right after A's final issue.
        do_reset();
        set_req(2, 1, 8);
        @(negedge clk);
        check("b2b_accept_a", req_ready, 1);
        for (int c = 1; c <= 10; c++) begin
            tick();
            if (c == 1) set_req(1, 1, 8);
            if (c == 4) req_valid = 1'b0;
            @(negedge clk);
            check("b2b_ready", req_ready, (c == 3 || c >= 5));
            check("b2b_valid", rsp_valid, (c == 5 || c == 6 || c == 8));
            check("b2b_last", rsp_valid && rsp.last, (c == 6 || c == 8));
        end
        check("b2b_count", rsp_count, 3);

        // Reset mid-expansion drops everything in flight.
        do_reset();
        set_req(10, 1, 8);
        @(negedge clk);
        check("mr_accept", req_ready, 1);
        for (int c = 1; c <= 15; c++) begin
            tick();
            req_valid = 1'b0;
            rst       = (c == 3);
            @(negedge clk);
            if (c >= 4) begin
                check("mr_valid", rsp_valid, 0);
                check("mr_busy", busy, 0);
                check("mr_count", rsp_count, 0);
                check("mr_ready", req_ready, 1);
            end
        end

        // Randomized traffic against the queue model.
        do_reset();
        for (int c = 0; c < 400; c++) begin
            if (req_valid && accepted) req_valid = 1'b0;
            if (!req_valid && $urandom_range(0, 3) == 0) begin
                set_req($urandom_range(0, 5), $urandom_range(0, 3),
                        ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 64));
            end
            rsp_ready = ($urandom_range(0, 9) < 7);
            @(negedge clk);
            accepted = req_valid && req_ready;
            tick();
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        for (int c = 0; c < 300; c++) begin
            if (exp_q.size() == 0 && !busy) break;
            tick();
        end
        @(negedge clk);
        check("drain_empty", exp_q.size(), 0);
        check("drain_busy", busy, 0);
        check("drain_count", rsp_count, model_pops);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
